icache_line_filler: RTL and testbench

- Sits directly downstream of the instruction cache, on its memory side.
- Accepts a line-fill request (memRead/memAddress) and performs BLOCK_SIZE/4 sequential 32-bit reads on the word-wide instruction bus, then assembles the full line.
- Presents the line on memReadData and signals completion by dropping memBusy, matching the cache's READMEM/WAIT handshake.

---
 rtl/icache_line_filler_pkg.sv | 20 ++
 rtl/icache_line_filler.sv | 117 +++++++++++
 tb/tb_icache_line_filler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_line_filler_pkg.sv
// Shared types and constants for the instruction-cache line filler.
// Word 0 of a line sits in the most significant bits.
package icache_line_filler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } fillState_t;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    function automatic int unsigned wordLsb(
        input int unsigned lineBits,
        input int unsigned k
    );
        return lineBits - 32 - 32 * k;
    endfunction

endpackage

// File: rtl/icache_line_filler.sv
// Fills one instruction-cache line by issuing sequential word reads
// on the instruction bus and assembling them into a single line.
module icache_line_filler
    import icache_line_filler_pkg::*;
#(
    parameter int BLOCK_SIZE = 32,
    parameter int ADDR_WIDTH = 32,
    localparam int LINE_BITS = BLOCK_SIZE * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memRead,
    input  logic [ADDR_WIDTH-1:0] memAddress,
    output logic                  memBusy,
    output logic [LINE_BITS-1:0]  memReadData,
    output logic                  busReq,
    output logic [ADDR_WIDTH-1:0] busAddr,
    input  logic                  busReady,
    input  logic [31:0]           busRData,
    input  logic                  busRValid,
    input  logic                  busErr,
    output logic                  fillErr
);

    localparam int WORDS = BLOCK_SIZE / 4;
    localparam int CNT_WIDTH = $clog2(WORDS) + 1;
    localparam int POS_WIDTH = $clog2(LINE_BITS);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
        ~ADDR_WIDTH'(BLOCK_SIZE - 1);

    fillState_t state;
    fillState_t stateNext;

    logic [ADDR_WIDTH-1:0] lineBase;
    logic [CNT_WIDTH-1:0]  wordIdx;
    logic [LINE_BITS-1:0]  lineReg;
    logic                  errReg;

    logic                  accept;
    logic                  respond;
    logic                  lastWord;
    logic [POS_WIDTH-1:0]  slotLsb;
    logic [31:0]           slotData;

    assign accept   = (state == IDLE) && memRead;
    assign respond  = (state == RESP) && busRValid;
    assign lastWord = (wordIdx == CNT_WIDTH'(WORDS - 1));
    assign slotLsb  = POS_WIDTH'(wordLsb(LINE_BITS, 32'(wordIdx)));
    // Failed reads are patched with a NOP so the core never runs garbage.
    assign slotData = busErr ? NOP_INSN : busRData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (memRead) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (busReady) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (busRValid) begin
                    stateNext = lastWord ? IDLE : REQ;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lineBase <= '0;
            wordIdx  <= '0;
            lineReg  <= '0;
            errReg   <= 1'b0;
        end else begin
            if (accept) begin
                lineBase <= memAddress & BASE_MASK;
                wordIdx  <= '0;
                errReg   <= 1'b0;
            end
            if (respond) begin
                lineReg[slotLsb +: 32] <= slotData;
                errReg <= errReg | busErr;
                if (!lastWord) begin
                    wordIdx <= wordIdx + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Busy follows the registered state, so it rises the cycle after accept.
    always_comb begin
        memBusy = (state != IDLE);
        busReq  = (state == REQ);
        busAddr = '0;
        if (state == REQ) begin
            busAddr = lineBase + ADDR_WIDTH'({wordIdx, 2'b00});
        end
    end

    assign memReadData = lineReg;
    assign fillErr     = errReg;

endmodule

// File: tb/tb_icache_line_filler.sv
// Bench for icache_line_filler: directed table, corner sequences and
// randomized fills checked against a line-level reference model.
module tb_icache_line_filler;

    localparam int BS    = 32;
    localparam int AW    = 32;
    localparam int LB    = BS * 8;
    localparam int WORDS = BS / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          memRead;
    logic [AW-1:0] memAddress;
    logic          memBusy;
    logic [LB-1:0] memReadData;
    logic          busReq;
    logic [AW-1:0] busAddr;
    logic          busReady;
    logic [31:0]   busRData;
    logic          busRValid;
    logic          busErr;
    logic          fillErr;

    icache_line_filler #(
        .BLOCK_SIZE(BS),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .memRead(memRead),
        .memAddress(memAddress),
        .memBusy(memBusy),
        .memReadData(memReadData),
        .busReq(busReq),
        .busAddr(busAddr),
        .busReady(busReady),
        .busRData(busRData),
        .busRValid(busRValid),
        .busErr(busErr),
        .fillErr(fillErr)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;
    int busyCnt;

    logic [31:0]   fData [WORDS];
    int            fStall[WORDS];
    int            fDelay[WORDS];
    logic [WORDS-1:0] fErr;
    logic [LB-1:0] lastLine;
    logic          lastErr;

    typedef struct {
        logic [31:0] addr;
        int          stallWord;
        int          stallN;
        int          delayWord;
        int          delayN;
        int          errWord;
        bit          hold;
        logic [31:0] expBase;
        int          expBusy;
        bit          expErr;
    } vec_t;

    task automatic chk(input string name, input logic [LB-1:0] act,
                       input logic [LB-1:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (memBusy) busyCnt++;
    endtask

    task automatic reqWord(input string tag, input logic [31:0] expAddr,
                           input int stall);
        int n;
        n = 0;
        while (!busReq && n < 50) begin
            step();
            n++;
        end
        if (!busReq) begin
            nTests++;
            nFail++;
            $display("FAIL %s.reqTimeout: got busReq=0 expected 1", tag);
            return;
        end
        chk($sformatf("%s.busAddr", tag), busAddr, expAddr);
        for (int s = 0; s < stall; s++) begin
            busReady = 1'b0;
            step();
            chk($sformatf("%s.stallHold", tag), {busReq, busAddr},
                {1'b1, expAddr});
        end
        busReady = 1'b1;
        step();
        busReady = 1'b0;
        chk($sformatf("%s.reqDrop", tag), busReq, 0);
    endtask

    task automatic respWord(input int delay, input logic [31:0] data,
                            input logic err);
        for (int d = 0; d < delay; d++) step();
        busRValid = 1'b1;
        busRData  = data;
        busErr    = err;
        step();
        busRValid = 1'b0;
        busErr    = 1'b0;
        busRData  = $urandom;
    endtask

    task automatic doFill(input string tag, input logic [31:0] addr,
                          input logic [31:0] expBase, input int expBusy,
                          input bit expErr, input bit holdRead);
        logic [LB-1:0] expLine;
        expLine = '0;
        for (int i = 0; i < WORDS; i++) begin
            expLine = (expLine << 32) |
                      LB'(fErr[i] ? 32'h00000013 : fData[i]);
        end
        memRead    = 1'b1;
        memAddress = addr;
        busyCnt    = 0;
        step();
        chk($sformatf("%s.busyRise", tag), memBusy, 1);
        chk($sformatf("%s.errCleared", tag), fillErr, 0);
        chk($sformatf("%s.lineHeld", tag), memReadData, lastLine);
        if (!holdRead) memRead = 1'b0;
        memAddress = $urandom;
        for (int i = 0; i < WORDS; i++) begin
            reqWord(tag, expBase + 32'(4 * i), fStall[i]);
            respWord(fDelay[i], fData[i], fErr[i]);
        end
        memRead = 1'b0;
        chk($sformatf("%s.busyFall", tag), memBusy, 0);
        chk($sformatf("%s.busyCycles", tag), busyCnt, expBusy);
        chk($sformatf("%s.line", tag), memReadData, expLine);
        chk($sformatf("%s.fillErr", tag), fillErr, expErr);
        lastLine = expLine;
        lastErr  = expErr;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("%s.postIdle", tag), {memBusy, busReq}, 0);
            chk($sformatf("%s.lineStable", tag), memReadData, expLine);
        end
    endtask

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        memRead    = 1'b0;
        memAddress = '0;
        busReady   = 1'b0;
        busRData   = '0;
        busRValid  = 1'b0;
        busErr     = 1'b0;
        lastLine   = '0;
        lastErr    = 1'b0;
        busyCnt    = 0;

        vecs[0] = '{32'h0000_1234, -1, 0, -1, 0, -1, 0,
                    32'h0000_1220, 16, 0};
        vecs[1] = '{32'h0000_1234, 2, 3, 5, 2, -1, 0,
                    32'h0000_1220, 21, 0};
        vecs[2] = '{32'h0000_1234, -1, 0, -1, 0, -1, 1,
                    32'h0000_1220, 16, 0};
        vecs[3] = '{32'h0000_0100, -1, 0, -1, 0, 3, 0,
                    32'h0000_0100, 16, 1};
        vecs[4] = '{32'h0000_0104, -1, 0, -1, 0, -1, 0,
                    32'h0000_0100, 16, 0};
        vecs[5] = '{32'hFFFF_FFFF, 1, 1, 0, 1, -1, 0,
                    32'hFFFF_FFE0, 18, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset.outputs", {memBusy, busReq, busAddr, fillErr}, 0);
        chk("reset.line", memReadData, 0);
        rst = 1'b0;
        step();
        chk("afterReset.outputs", {memBusy, busReq, busAddr, fillErr}, 0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < WORDS; i++) begin
                fData[i]  = 32'hA000_0000 + 32'(i);
                fStall[i] = (i == vecs[v].stallWord) ? vecs[v].stallN : 0;
                fDelay[i] = (i == vecs[v].delayWord) ? vecs[v].delayN : 0;
                fErr[i]   = (i == vecs[v].errWord);
            end
            doFill($sformatf("vec%0d", v), vecs[v].addr, vecs[v].expBase,
                   vecs[v].expBusy, vecs[v].expErr, vecs[v].hold);
            if (v == 0) begin
                chk("vec0.msbWord", memReadData[255:224], 32'hA000_0000);
                chk("vec0.lsbWord", memReadData[31:0], 32'hA000_0007);
            end
            if (v == 3) begin
                chk("vec3.nopSlot", memReadData[159:128], 32'h0000_0013);
                chk("vec3.slot2", memReadData[191:160], 32'hA000_0002);
            end
        end

        busRValid = 1'b1;
        busErr    = 1'b1;
        busRData  = 32'hDEAD_BEEF;
        step();
        step();
        busRValid = 1'b0;
        busErr    = 1'b0;
        chk("spurious.idle", {memBusy, busReq}, 0);
        chk("spurious.line", memReadData, lastLine);
        chk("spurious.fillErr", fillErr, lastErr);

        for (int i = 0; i < WORDS; i++) begin
            fData[i]  = 32'h5500_0000 + 32'(i);
            fStall[i] = 0;
            fDelay[i] = 0;
        end
        fErr = '0;
        memRead    = 1'b1;
        memAddress = 32'h0000_2010;
        step();
        memRead = 1'b0;
        for (int i = 0; i < 4; i++) begin
            reqWord("rstMid", 32'h0000_2000 + 32'(4 * i), 0);
            respWord(0, fData[i], 1'b0);
        end
        reqWord("rstMid", 32'h0000_2010, 0);
        rst = 1'b1;
        #1;
        chk("rstMid.outputs", {memBusy, busReq, busAddr, fillErr}, 0);
        chk("rstMid.line", memReadData, 0);
        step();
        rst = 1'b0;
        busRValid = 1'b1;
        busRData  = 32'h1234_5678;
        busErr    = 1'b1;
        step();
        busRValid = 1'b0;
        busErr    = 1'b0;
        step();
        chk("lateResp.outputs", {memBusy, busReq, busAddr, fillErr}, 0);
        chk("lateResp.line", memReadData, 0);
        lastLine = '0;
        lastErr  = 1'b0;
        doFill("afterRst", 32'h0000_3000, 32'h0000_3000, 16, 0, 0);

        for (int r = 0; r < 20; r++) begin
            logic [31:0] a;
            int extra;
            a = $urandom;
            extra = 0;
            for (int i = 0; i < WORDS; i++) begin
                fData[i]  = $urandom;
                fStall[i] = $urandom_range(0, 3);
                fDelay[i] = $urandom_range(0, 3);
                fErr[i]   = ($urandom_range(0, 7) == 0);
                extra += fStall[i] + fDelay[i];
            end
            doFill($sformatf("rnd%0d", r), a, a - (a % BS),
                   2 * WORDS + extra, |fErr, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
